// File: rtl/note_player.sv
// Square-wave note player: accepts (half_period, duration) commands and drives
// a speaker toggle for duration milliseconds, with stop and completion pulse.
module note_player #(
    parameter int PERIOD_W = 16,
    parameter int DUR_W    = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PERIOD_W-1:0] ticks_per_milli,
    input  logic                note_valid,
    output logic                note_ready,
    input  logic [PERIOD_W-1:0] note_half_period,
    input  logic [DUR_W-1:0]    note_duration_ms,
    input  logic                stop,
    output logic                sound,
    output logic                busy,
    output logic                note_done
);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t              state, state_nx;
    logic [PERIOD_W-1:0] half_q, half_nx;
    logic [PERIOD_W-1:0] tick_q, tick_nx;
    logic [PERIOD_W-1:0] tone_cnt, tone_nx;
    logic [PERIOD_W-1:0] ms_cnt, ms_nx;
    logic [DUR_W-1:0]    remain, remain_nx;
    logic                sound_nx, done_nx;
    logic                ms_wrap, tone_wrap;

    assign note_ready = (state == IDLE);
    assign busy       = (state == PLAY);
    assign ms_wrap    = (ms_cnt == tick_q - PERIOD_W'(1));
    assign tone_wrap  = (tone_cnt == half_q - PERIOD_W'(1));

    always_comb begin
        state_nx  = state;
        half_nx   = half_q;
        tick_nx   = tick_q;
        tone_nx   = tone_cnt;
        ms_nx     = ms_cnt;
        remain_nx = remain;
        sound_nx  = sound;
        done_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (note_valid) begin
                    state_nx  = PLAY;
                    half_nx   = note_half_period;
                    // a zero tick rate would never wrap; run it as one cycle per ms
                    tick_nx   = (ticks_per_milli == '0) ? PERIOD_W'(1) : ticks_per_milli;
                    tone_nx   = '0;
                    ms_nx     = '0;
                    remain_nx = note_duration_ms;
                    sound_nx  = 1'b0;
                end
            end
            PLAY: begin
                if (stop || remain == '0 || (ms_wrap && remain == DUR_W'(1))) begin
                    state_nx  = IDLE;
                    tone_nx   = '0;
                    ms_nx     = '0;
                    remain_nx = '0;
                    sound_nx  = 1'b0;
                    done_nx   = !stop;
                end else begin
                    if (half_q == '0) begin
                        sound_nx = 1'b0;
                    end else if (tone_wrap) begin
                        tone_nx  = '0;
                        sound_nx = !sound;
                    end else begin
                        tone_nx = tone_cnt + PERIOD_W'(1);
                    end
                    if (ms_wrap) begin
                        ms_nx     = '0;
                        remain_nx = remain - DUR_W'(1);
                    end else begin
                        ms_nx = ms_cnt + PERIOD_W'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            half_q    <= '0;
            tick_q    <= '0;
            tone_cnt  <= '0;
            ms_cnt    <= '0;
            remain    <= '0;
            sound     <= 1'b0;
            note_done <= 1'b0;
        end else begin
            state     <= state_nx;
            half_q    <= half_nx;
            tick_q    <= tick_nx;
            tone_cnt  <= tone_nx;
            ms_cnt    <= ms_nx;
            remain    <= remain_nx;
            sound     <= sound_nx;
            note_done <= done_nx;
        end
    end

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player: per-cycle waveform model of each note plus
// hand-timed back-to-back, stop and reset scenarios.
module tb_note_player;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ticks_per_milli = '0;
    logic        note_valid = 1'b0;
    logic        note_ready;
    logic [15:0] note_half_period = '0;
    logic [11:0] note_duration_ms = '0;
    logic        stop = 1'b0;
    logic        sound, busy, note_done;

    int checks = 0;
    int failures = 0;

    note_player dut (
        .clk(clk), .rst_n(rst_n), .ticks_per_milli(ticks_per_milli),
        .note_valid(note_valid), .note_ready(note_ready),
        .note_half_period(note_half_period), .note_duration_ms(note_duration_ms),
        .stop(stop), .sound(sound), .busy(busy), .note_done(note_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input int half, input int dur, input int ticks);
        note_half_period = 16'(half);
        note_duration_ms = 12'(dur);
        ticks_per_milli  = 16'(ticks);
        note_valid       = 1'b1;
    endtask

    // Plays one note from an idle negedge and checks every cycle against the model.
    task automatic play_note(input string tag, input int half, input int dur, input int ticks);
        int t, len, bad, dones;
        logic exp_snd;
        t = (ticks == 0) ? 1 : ticks;
        len = (dur == 0) ? 1 : dur * t;
        bad = 0;
        dones = 0;
        load(half, dur, ticks);
        @(posedge clk);
        #1 note_valid = 1'b0;
        ticks_per_milli = 16'(ticks + 3);
        @(negedge clk);
        check({tag, "_acc_busy"}, {busy, note_ready, sound}, 3'b100);
        for (int k = 1; k <= len; k++) begin
            step();
            if (k < len) begin
                exp_snd = (half == 0) ? 1'b0 : 1'(((k / half) % 2));
                if ({busy, note_done, sound} !== {1'b1, 1'b0, exp_snd}) bad++;
            end else begin
                if ({busy, sound} !== 2'b00) bad++;
            end
            if (note_done) dones++;
        end
        check({tag, "_wave"}, bad, 0);
        check({tag, "_done_at_end"}, note_done, 1);
        step();
        check({tag, "_done_pulse"}, {note_done, busy, note_ready}, 3'b001);
        check({tag, "_done_count"}, dones, 1);
    endtask

    initial begin
        #12;
        check("rst_state", {sound, busy, note_ready, note_done}, 4'b0010);
        #1 rst_n = 1'b1;
        @(negedge clk);

        play_note("n10_5_3", 5, 3, 10);
        play_note("rest", 0, 2, 4);
        play_note("dur0", 3, 0, 5);
        play_note("tick0", 2, 2, 0);

        // stop in IDLE does nothing
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_idle", {note_ready, busy, note_done}, 3'b100);

        // back-to-back: note 2 held valid while note 1 plays
        load(2, 1, 6);
        @(posedge clk);
        #1 load(3, 1, 6);
        @(negedge clk);
        step(); step();
        check("b2b_n1_snd2", sound, 1);
        step(); step();
        check("b2b_n1_snd4", sound, 0);
        step(); step();
        check("b2b_n1_done", {note_done, note_ready}, 2'b11);
        step();
        note_valid = 1'b0;
        check("b2b_n2_acc", {busy, note_done, sound}, 3'b100);
        step(); step();
        check("b2b_n2_snd2", sound, 0);
        step();
        check("b2b_n2_snd3", sound, 1);
        step(); step(); step();
        check("b2b_n2_done", {note_done, busy, sound}, 3'b100);
        step();

        // stop 7 cycles into a 30-cycle note
        load(5, 3, 10);
        @(posedge clk);
        #1 note_valid = 1'b0;
        @(negedge clk);
        repeat (7) step();
        check("stop_pre_snd", sound, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_mid", {busy, sound, note_done}, 3'b000);
        step();
        check("stop_mid_nodone", {note_done, note_ready}, 2'b01);

        // stop coincident with the final wrap
        load(0, 1, 4);
        @(posedge clk);
        #1 note_valid = 1'b0;
        @(negedge clk);
        repeat (3) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_wrap", {busy, note_done}, 2'b00);
        step();
        check("stop_wrap_after", note_done, 0);

        // async reset mid-note while sound is high
        load(5, 3, 10);
        @(posedge clk);
        #1 note_valid = 1'b0;
        @(negedge clk);
        repeat (6) step();
        check("rst_pre_snd", {sound, busy}, 2'b11);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async", {sound, busy, note_ready, note_done}, 4'b0010);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_after", {busy, note_done}, 2'b00);
        play_note("post_rst", 4, 2, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/note_player.md
NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001 The block SHALL have parameter PERIOD_W, default 16, width of the half-period and tick fields.
REQ-002 The block SHALL have parameter DUR_W, default 12, width of the duration field in milliseconds.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port ticks_per_milli, input, PERIOD_W, clk cycles per millisecond.
REQ-006 The block SHALL have port note_valid, input, 1, upstream note command is present.
REQ-007 The block SHALL have port note_ready, output, 1, block can accept a note.
REQ-008 The block SHALL have port note_half_period, input, PERIOD_W, clk cycles per half square-wave period; 0 means rest (silence).
REQ-009 The block SHALL have port note_duration_ms, input, DUR_W, note length in milliseconds.
REQ-010 The block SHALL have port stop, input, 1, synchronous abort of the current note.
REQ-011 The block SHALL have port sound, output, 1, square-wave speaker drive.
REQ-012 The block SHALL have port busy, output, 1, high while a note is playing.
REQ-013 The block SHALL have port note_done, output, 1, one-cycle pulse when a note completes normally.

Function
REQ-014 The FSM SHALL have two states: IDLE and PLAY; note_ready = (state==IDLE), busy = (state==PLAY).
REQ-015 A note SHALL be accepted on a rising edge where note_valid && note_ready; at that edge half_period, duration and ticks_per_milli are latched, tone_cnt=0, ms_cnt=0, remaining=duration, sound=0, state=PLAY.
REQ-016 A latched ticks_per_milli of 0 SHALL be treated as 1; later changes to the ticks_per_milli input SHALL NOT affect the note in progress.
REQ-017 In PLAY with half_period!=0, each cycle: if tone_cnt==half_period-1 then tone_cnt=0 and sound toggles, else tone_cnt+1; first rising of sound occurs half_period cycles after the accept edge.
REQ-018 In PLAY with half_period==0, sound SHALL be held 0 for the whole note.
REQ-019 In PLAY, each cycle: if ms_cnt==T-1 (T = latched ticks) then ms_cnt=0 and remaining decrements, else ms_cnt+1.
REQ-020 When ms_cnt wraps with remaining==1, at that edge state SHALL go IDLE, sound=0, and note_done=1 for exactly one cycle; total note length is duration*T cycles after the accept edge.
REQ-021 A note with duration 0 SHALL be accepted, and the block SHALL return to IDLE with note_done pulsed on the next edge, sound staying 0.
REQ-022 A new note SHALL be acceptable in the cycle note_done is high (back-to-back, no idle gap beyond that cycle).
REQ-023 stop high in PLAY SHALL on that edge force IDLE, sound=0, counters cleared, with no note_done; stop in IDLE SHALL have no effect; stop has priority over note completion in the same cycle.
REQ-024 note_valid while busy SHALL be ignored; upstream holds the command until note_ready.
REQ-025 Counter arithmetic SHALL be unsigned at the declared widths with no overflow, since comparisons are against latched values.

Reset
REQ-026 While rst_n is low, state=IDLE, sound=0, note_done=0, busy=0, note_ready=1, all counters and latched fields SHALL be 0, taking effect asynchronously.
REQ-027 Reset asserted mid-note SHALL abort the note immediately with no note_done; after rst_n deasserts, the first clk edge may accept a note.

Verification
REQ-028 ticks_per_milli=10, note half=5, dur=3 -> sound toggles every 5 cycles (3 full periods), note_done pulses 30 cycles after accept, sound 0 after.
REQ-029 half=0, dur=2, ticks=4 -> sound constant 0, busy for 8 cycles, single note_done pulse.
REQ-030 dur=0 -> accept, note_done next edge, sound never high; ticks_per_milli=0 with dur=2 -> done after 2 cycles.
REQ-031 Two notes held valid back-to-back (half=2,dur=1; half=3,dur=1; ticks=6) -> second accepted in note_done cycle, sound restarts at 0.
REQ-032 stop asserted 7 cycles into a 30-cycle note -> busy drops, sound 0, no note_done; stop coincident with final wrap -> no note_done.
REQ-033 rst_n pulsed low mid-note with sound=1 -> sound, busy 0 without a clock edge; next note plays normally.
